// File: rtl/amba_apb_if.sv
// rtl/amba_apb_if.sv - APB-style bus bundle between a requester and amba_apb
//
// Signals:
//   address     word index of the transfer
//   select      PSEL, a transfer is requested
//   enable      PENABLE, access phase
//   write_en    1 = write, 0 = read
//   write_data  data for a write
//   ready       PREADY, one-cycle completion pulse
//   slave_error PSLVERR, valid only while ready=1
//   read_data   registered read result
interface amba_apb_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] address;
    logic                  select;
    logic                  enable;
    logic                  write_en;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  ready;
    logic                  slave_error;
    logic [DATA_WIDTH-1:0] read_data;

    modport master (
        output address, select, enable, write_en, write_data,
        input  ready, slave_error, read_data
    );

    modport slave (
        input  address, select, enable, write_en, write_data,
        output ready, slave_error, read_data
    );
endinterface

// File: rtl/amba_apb.sv
// rtl/amba_apb.sv - APB-style register slave backed by a MEM_DEPTH-word memory
//
// Ports:
//   clock  sole clock, rising edge
//   reset  synchronous active-low reset; clears state, outputs and all storage
//   bus    amba_apb_if.slave (address, select, enable, write_en, write_data,
//          ready, slave_error, read_data)
//
// Optional feature: define AMBA_APB_SLVERR_EN to flag addresses >= MEM_DEPTH
// with slave_error (write dropped, read returns 0). Without it the address
// wraps onto the low log2(MEM_DEPTH) bits and slave_error is always 0.
module amba_apb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_DEPTH  = 64
) (
    input  logic        clock,
    input  logic        reset,
    amba_apb_if.slave   bus
);
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } state_t;

    state_t                current_state;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic                  ready_q;
    logic                  slverr_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic [IDX_W-1:0]      idx;
    logic                  in_range;

    assign idx = bus.address[IDX_W-1:0];

`ifdef AMBA_APB_SLVERR_EN
    assign in_range = (bus.address < ADDR_WIDTH'(MEM_DEPTH));
`else
    // Upper address bits are deliberately ignored: storage wraps modulo depth.
    assign in_range = 1'b1;
    wire unused_addr_hi = &{1'b0, bus.address[ADDR_WIDTH-1:IDX_W]};
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            current_state <= IDLE;
            ready_q       <= 1'b0;
            slverr_q      <= 1'b0;
            rdata_q       <= '0;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            // ready/slave_error are pulses: only the commit edge raises them.
            ready_q  <= 1'b0;
            slverr_q <= 1'b0;
            case (current_state)
                IDLE: begin
                    if (bus.select) begin
                        current_state <= SETUP;
                    end
                end
                SETUP: begin
                    if (bus.select && bus.enable) begin
                        // Commit edge: the transfer uses the inputs sampled here.
                        current_state <= ACCESS;
                        ready_q       <= 1'b1;
                        slverr_q      <= !in_range;
                        if (bus.write_en) begin
                            if (in_range) begin
                                mem[idx] <= bus.write_data;
                            end
                        end else begin
                            rdata_q <= in_range ? mem[idx] : '0;
                        end
                    end else if (!bus.select) begin
                        current_state <= IDLE;
                    end
                end
                ACCESS: begin
                    // select without enable starts the next transfer directly.
                    if (bus.select && !bus.enable) begin
                        current_state <= SETUP;
                    end else begin
                        current_state <= IDLE;
                    end
                end
                default: current_state <= IDLE;
            endcase
        end
    end

    assign bus.ready       = ready_q;
    assign bus.slave_error = slverr_q;
    assign bus.read_data   = rdata_q;
endmodule

// File: tb/tb_amba_apb.sv
// tb/tb_amba_apb.sv - scoreboard testbench for amba_apb
module tb_amba_apb;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 64;

`ifdef AMBA_APB_SLVERR_EN
    localparam bit SLVERR_EN = 1'b1;
`else
    localparam bit SLVERR_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;

    amba_apb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    amba_apb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [DW-1:0] rd;
        logic          err;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] model_rd;
    int            errors = 0;
    int            checks = 0;
    bit            mon_en = 1'b0;
    logic          prev_ready = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        model_rd = '0;
    endfunction

    // Reference behaviour: one call per committed transfer, in issue order.
    function automatic exp_t model_xfer(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        bit   bad;
        int   w;
        bad = SLVERR_EN && (a >= AW'(DEPTH));
        w   = int'(a % AW'(DEPTH));
        if (wr) begin
            if (!bad) model_mem[w] = d;
        end else begin
            model_rd = bad ? '0 : model_mem[w];
        end
        e.rd  = model_rd;
        e.err = bad;
        return e;
    endfunction

    // Monitor: every ready pulse pops one expectation.
    always @(negedge clock) begin
        if (mon_en) begin
            if (bus.ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ready", 64'(bus.ready), 64'(0));
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("read_data", 64'(bus.read_data), 64'(e.rd));
                    chk("slave_error", 64'(bus.slave_error), 64'(e.err));
                end
                if (prev_ready === 1'b1) chk("ready_single_cycle", 64'(prev_ready), 64'(0));
            end else begin
                chk("slverr_without_ready", 64'(bus.slave_error), 64'(0));
            end
            prev_ready = bus.ready;
        end
    end

    // Called at a negedge with the FSM in IDLE or ACCESS; returns at the
    // negedge of the ACCESS cycle. setup_wait extra cycles hold SETUP.
    task automatic xfer(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int setup_wait);
        bus.select     = 1'b1;
        bus.enable     = 1'b0;
        bus.write_en   = wr;
        bus.address    = a;
        bus.write_data = d;
        exp_q.push_back(model_xfer(wr, a, d));
        @(negedge clock);
        chk("state_setup", 64'(dut.current_state), 64'(2'b01));
        for (int i = 0; i < setup_wait; i++) begin
            @(negedge clock);
            chk("state_setup_hold", 64'(dut.current_state), 64'(2'b01));
        end
        bus.enable = 1'b1;
        @(negedge clock);
        chk("state_access", 64'(dut.current_state), 64'(2'b10));
        chk("ready_latency", 64'(bus.ready), 64'(1));
    endtask

    task automatic go_idle();
        bus.select = 1'b0;
        bus.enable = 1'b0;
        @(negedge clock);
        chk("state_idle", 64'(dut.current_state), 64'(2'b00));
        chk("ready_idle", 64'(bus.ready), 64'(0));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.select = 1'b0;
        bus.enable = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [DW-1:0] wvals [3];
        wvals[0] = 32'hA5A5A5A5;
        wvals[1] = 32'h12345678;
        wvals[2] = 32'hDEADBEEF;
        bus.select = 1'b0; bus.enable = 1'b0; bus.write_en = 1'b0;
        bus.address = '0; bus.write_data = '0;

        repeat (3) @(negedge clock);
        reset = 1'b1;
        model_reset();
        chk("reset_state", 64'(dut.current_state), 64'(2'b00));
        chk("reset_ready", 64'(bus.ready), 64'(0));
        chk("reset_slverr", 64'(bus.slave_error), 64'(0));
        chk("reset_read_data", 64'(bus.read_data), 64'(0));
        mon_en = 1'b1;

        for (int i = 0; i < 3; i++) begin
            xfer(1'b1, AW'(i), wvals[i], 0);
            go_idle();
        end
        for (int i = 0; i < 3; i++) begin
            xfer(1'b0, AW'(i), '0, 0);
            go_idle();
        end

        // Back-to-back write/read of word 3: no IDLE cycle between them.
        xfer(1'b1, 32'd3, 32'h5555AAAA, 0);
        xfer(1'b0, 32'd3, '0, 0);
        go_idle();

        // Out-of-range address: error with macro, wraps to 36 without it.
        xfer(1'b1, 32'd100, 32'h11111111, 0);
        go_idle();
        xfer(1'b0, 32'd100, '0, 0);
        go_idle();
        xfer(1'b0, 32'd36, '0, 0);
        go_idle();

        // Reset during the SETUP of a write: storage must stay untouched.
        bus.select = 1'b1; bus.enable = 1'b0; bus.write_en = 1'b1;
        bus.address = 32'd5; bus.write_data = 32'hCAFEF00D;
        @(negedge clock);
        chk("pre_reset_setup", 64'(dut.current_state), 64'(2'b01));
        reset = 1'b0;
        bus.enable = 1'b1;
        @(negedge clock);
        chk("reset_abort_state", 64'(dut.current_state), 64'(2'b00));
        chk("reset_abort_ready", 64'(bus.ready), 64'(0));
        reset = 1'b1;
        bus.select = 1'b0;
        bus.enable = 1'b0;
        model_reset();
        @(negedge clock);
        xfer(1'b0, 32'd5, '0, 0);
        go_idle();

        // Random traffic, including wrapping/out-of-range addresses,
        // stretched SETUP phases and back-to-back chains.
        for (int n = 0; n < 60; n++) begin
            bit            wr;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            wr = 1'($urandom_range(0, 1));
            a  = AW'($urandom_range(0, 2 * DEPTH - 1));
            d  = $urandom;
            xfer(wr, a, d, $urandom_range(0, 2));
            if ($urandom_range(0, 2) == 0) go_idle();
            if (n == 30) begin
                go_idle();
                do_reset();
                @(negedge clock);
            end
        end
        go_idle();
        repeat (2) @(negedge clock);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
